// File: rtl/ysyx_24100029_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_wbu -- writeback / commit stage
//
// Takes one retired instruction per cycle from the LSU stage, holds it for a
// single commit cycle and, on the edge that ends that cycle, updates the
// register file, the machine CSRs and the retired-instruction counter.
// An ebreak commit halts the core: the stage stops accepting entries and
// freezes its state until reset.
//
// Ports
//   clock, reset            sole clock, synchronous active-high reset
//   valid_last/ready_last   upstream handshake (ready_last = ~halt)
//   pc .. jump_flag         instruction fields from the LSU stage
//   rs1_addr/rs2_addr       combinational GPR read addresses
//   rs1_data/rs2_data       read data, bypassed from the committing entry
//   mstatus_o .. mcause_o   current machine CSR values (no bypass)
//   commit_*                commit-cycle view of the staged instruction
//   instret                 64-bit retired-instruction counter
//   halt                    sticky ebreak halt flag
// ----------------------------------------------------------------------------
module ysyx_24100029_wbu #(
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        valid_last,
    output logic        ready_last,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        R_wen,
    input  logic [4:0]  rd,
    input  logic        mem_ren,
    input  logic [31:0] Ex_result,
    input  logic [31:0] LSU_Rdata,
    input  logic [3:0]  csr_wen,
    input  logic [31:0] csrs,
    input  logic        jump_flag,

    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,

    output logic [31:0] mstatus_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,

    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [31:0] commit_inst,
    output logic        commit_jump,
    output logic [63:0] instret,
    output logic        halt
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    // Stage registers
    logic        stage_valid;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic        R_wen_reg;
    logic [4:0]  rd_reg;
    logic        mem_ren_reg;
    logic [31:0] Ex_result_reg;
    logic [31:0] LSU_Rdata_reg;
    logic [3:0]  csr_wen_reg;
    logic [31:0] csrs_reg;
    logic        jump_flag_reg;

    // Architectural state
    logic [31:0] gpr [0:31];
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic [31:0] wb_data;
    logic        gpr_we;
    logic        accept;

    assign ready_last = ~halt;
    assign accept     = valid_last & ready_last;
    assign wb_data    = mem_ren_reg ? LSU_Rdata_reg : Ex_result_reg;
    assign gpr_we     = stage_valid & R_wen_reg & (rd_reg != 5'd0);

    assign commit_valid = stage_valid;
    assign commit_pc    = pc_reg;
    assign commit_inst  = inst_reg;
    assign commit_jump  = jump_flag_reg;

    assign mstatus_o = mstatus;
    assign mtvec_o   = mtvec;
    assign mepc_o    = mepc;
    assign mcause_o  = mcause;

    // Write-first read ports: the committing entry's result is visible in the
    // same cycle so a dependent reader upstream never sees a stale value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        if (rs1_addr != 5'd0)
            rs1_data = (gpr_we && rs1_addr == rd_reg) ? wb_data : gpr[rs1_addr];
        if (rs2_addr != 5'd0)
            rs2_data = (gpr_we && rs2_addr == rd_reg) ? wb_data : gpr[rs2_addr];
    end

    // Pipeline stage, counters and CSRs. Once halted nothing moves, so the
    // whole update is gated by ~halt.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_valid   <= 1'b0;
            pc_reg        <= 32'd0;
            inst_reg      <= 32'd0;
            R_wen_reg     <= 1'b0;
            rd_reg        <= 5'd0;
            mem_ren_reg   <= 1'b0;
            Ex_result_reg <= 32'd0;
            LSU_Rdata_reg <= 32'd0;
            csr_wen_reg   <= 4'd0;
            csrs_reg      <= 32'd0;
            jump_flag_reg <= 1'b0;
            instret       <= 64'd0;
            halt          <= 1'b0;
            mstatus       <= MSTATUS_RST;
            mtvec         <= 32'd0;
            mepc          <= 32'd0;
            mcause        <= 32'd0;
        end else if (!halt) begin
            // Capture and commit can share an edge: the old entry commits
            // below from the current registers while the new one loads here.
            stage_valid <= accept;
            if (accept) begin
                pc_reg        <= pc;
                inst_reg      <= inst;
                R_wen_reg     <= R_wen;
                rd_reg        <= rd;
                mem_ren_reg   <= mem_ren;
                Ex_result_reg <= Ex_result;
                LSU_Rdata_reg <= LSU_Rdata;
                csr_wen_reg   <= csr_wen;
                csrs_reg      <= csrs;
                jump_flag_reg <= jump_flag;
            end

            if (stage_valid) begin
                instret <= instret + 64'd1;
                if (inst_reg == EBREAK)
                    halt <= 1'b1;
                if (csr_wen_reg[0])
                    mstatus <= csrs_reg;
                if (csr_wen_reg[1])
                    mtvec <= csrs_reg;
                // Trap entry (mepc and mcause together) records the trapping
                // pc; a lone mepc write takes the CSR operand instead.
                if (csr_wen_reg[2])
                    mepc <= csr_wen_reg[3] ? pc_reg : csrs_reg;
                if (csr_wen_reg[3])
                    mcause <= csrs_reg;
            end
        end
    end

    // Register file. x0 is held at zero and never written.
    // NOTE: the GPR array is reset explicitly because a cleared register file
    // is architecturally visible here; most memories should not be reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                gpr[i] <= 32'd0;
        end else if (!halt && gpr_we) begin
            gpr[rd_reg] <= wb_data;
        end
    end

endmodule

// File: tb/tb_ysyx_24100029_wbu.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_24100029_wbu. Stimulus pushes the expected commit record
// into a queue; a monitor pops and compares on every commit_valid cycle.
// Architectural state is checked directly at chosen points.
// ----------------------------------------------------------------------------
module tb_ysyx_24100029_wbu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid_last = 1'b0;
    logic        ready_last;
    logic [31:0] pc = '0, inst = '0, Ex_result = '0, LSU_Rdata = '0, csrs = '0;
    logic        R_wen = 1'b0, mem_ren = 1'b0, jump_flag = 1'b0;
    logic [4:0]  rd = '0, rs1_addr = '0, rs2_addr = '0;
    logic [3:0]  csr_wen = '0;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] mstatus_o, mtvec_o, mepc_o, mcause_o;
    logic        commit_valid, commit_jump, halt;
    logic [31:0] commit_pc, commit_inst;
    logic [63:0] instret;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        jump;
    } commit_t;

    commit_t exp_q[$];
    int n_checks  = 0;
    int n_errors  = 0;
    int n_commits = 0;

    ysyx_24100029_wbu dut (
        .clock(clock), .reset(reset),
        .valid_last(valid_last), .ready_last(ready_last),
        .pc(pc), .inst(inst), .R_wen(R_wen), .rd(rd), .mem_ren(mem_ren),
        .Ex_result(Ex_result), .LSU_Rdata(LSU_Rdata), .csr_wen(csr_wen),
        .csrs(csrs), .jump_flag(jump_flag),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .mstatus_o(mstatus_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mcause_o(mcause_o),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_jump(commit_jump), .instret(instret), .halt(halt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one entry for one cycle; returns #1 after the capture edge.
    task automatic issue(input logic [31:0] p, input logic [31:0] i, input logic w,
                         input logic [4:0] d, input logic m, input logic [31:0] ex,
                         input logic [31:0] lsu, input logic [3:0] cw,
                         input logic [31:0] cs, input logic j, input bit push);
        commit_t e;
        pc = p; inst = i; R_wen = w; rd = d; mem_ren = m; Ex_result = ex;
        LSU_Rdata = lsu; csr_wen = cw; csrs = cs; jump_flag = j;
        valid_last = 1'b1;
        if (push) begin
            e.pc = p; e.inst = i; e.jump = j;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        valid_last = 1'b0;
    endtask

    // Monitor: every commit cycle must match the oldest expected record.
    always @(negedge clock) begin
        if (!reset && commit_valid) begin
            commit_t e;
            n_commits++;
            if (exp_q.size() == 0) begin
                check("unexpected_commit", {32'd0, commit_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("commit_pc", {32'd0, commit_pc}, {32'd0, e.pc});
                check("commit_inst", {32'd0, commit_inst}, {32'd0, e.inst});
                check("commit_jump", {63'd0, commit_jump}, {63'd0, e.jump});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        rs1_addr = 5'd5;
        @(negedge clock);
        check("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
        check("rst_halt", {63'd0, halt}, 64'd0);
        check("rst_ready", {63'd0, ready_last}, 64'd1);
        check("rst_instret", instret, 64'd0);
        check("rst_mstatus", {32'd0, mstatus_o}, 64'h1800);
        check("rst_mtvec", {32'd0, mtvec_o}, 64'd0);
        check("rst_mepc", {32'd0, mepc_o}, 64'd0);
        check("rst_mcause", {32'd0, mcause_o}, 64'd0);
        check("rst_x5", {32'd0, rs1_data}, 64'd0);

        // Load writeback with bypass
        issue(32'h8000_0000, 32'h0000_2283, 1, 5'd5, 1, 32'h8000_0010, 32'hDEAD_BEEF,
              4'd0, 32'd0, 0, 1);
        @(negedge clock);
        check("load_commit_valid", {63'd0, commit_valid}, 64'd1);
        check("load_bypass", {32'd0, rs1_data}, 64'hDEAD_BEEF);
        @(negedge clock);
        check("load_x5", {32'd0, rs1_data}, 64'hDEAD_BEEF);
        check("load_instret", instret, 64'd1);

        // x0 guard
        rs1_addr = 5'd0;
        rs2_addr = 5'd5;
        issue(32'h8000_0004, 32'h0000_0013, 1, 5'd0, 0, 32'h0000_1234, 32'd0,
              4'd0, 32'd0, 0, 1);
        @(negedge clock);
        check("x0_commit_cycle", {32'd0, rs1_data}, 64'd0);
        @(negedge clock);
        check("x0_after", {32'd0, rs1_data}, 64'd0);
        check("x0_x5_intact", {32'd0, rs2_data}, 64'hDEAD_BEEF);

        // CSRs: mtvec write, then trap entry back to back, then mstatus
        issue(32'h8000_0008, 32'h3050_1073, 0, 5'd0, 0, 32'd0, 32'd0,
              4'b0010, 32'h8000_0200, 0, 1);
        issue(32'h8000_0100, 32'h0000_0073, 0, 5'd0, 0, 32'd0, 32'd0,
              4'b1100, 32'd11, 1, 1);
        @(negedge clock);
        check("trap_no_bypass", {32'd0, mepc_o}, 64'd0);
        check("mtvec_written", {32'd0, mtvec_o}, 64'h8000_0200);
        @(negedge clock);
        check("trap_mepc", {32'd0, mepc_o}, 64'h8000_0100);
        check("trap_mcause", {32'd0, mcause_o}, 64'd11);
        check("trap_mtvec_kept", {32'd0, mtvec_o}, 64'h8000_0200);
        issue(32'h8000_0200, 32'h3000_1073, 0, 5'd0, 0, 32'd0, 32'd0,
              4'b0001, 32'h0000_0088, 0, 1);
        @(negedge clock);
        @(negedge clock);
        check("mstatus_written", {32'd0, mstatus_o}, 64'h88);
        check("csr_instret", instret, 64'd5);

        // Back-to-back: rd=1..4 on consecutive cycles
        for (int k = 1; k <= 4; k++)
            issue(32'h8000_0300 + 32'(k * 4), 32'h0000_0093, 1, 5'(k), 0,
                  32'h100 + 32'(k), 32'd0, 4'd0, 32'd0, k[0], 1);
        @(negedge clock);
        @(negedge clock);
        check("b2b_instret", instret, 64'd9);
        check("b2b_commits", 64'(n_commits), 64'd9);
        for (int k = 1; k <= 4; k++) begin
            rs1_addr = 5'(k);
            #1;
            check("b2b_xk", {32'd0, rs1_data}, 64'h100 + 64'(k));
        end

        // Ebreak halts; later entries ignored
        rs1_addr = 5'd6;
        rs2_addr = 5'd7;
        issue(32'h8000_0400, 32'h0010_0073, 1, 5'd6, 0, 32'h66, 32'd0,
              4'd0, 32'd0, 0, 1);
        @(negedge clock);
        check("ebreak_commit_halt", {63'd0, halt}, 64'd0);
        @(negedge clock);
        check("ebreak_halt", {63'd0, halt}, 64'd1);
        check("ebreak_ready", {63'd0, ready_last}, 64'd0);
        check("ebreak_instret", instret, 64'd10);
        check("ebreak_x6", {32'd0, rs1_data}, 64'h66);
        for (int k = 0; k < 3; k++)
            issue(32'h8000_0500, 32'h0000_0393, 1, 5'd7, 0, 32'h77, 32'd0,
                  4'b0001, 32'h0, 0, 0);
        repeat (3) @(negedge clock);
        check("halt_instret_hold", instret, 64'd10);
        check("halt_x7_untouched", {32'd0, rs2_data}, 64'd0);
        check("halt_sticky", {63'd0, halt}, 64'd1);
        check("halt_mstatus_hold", {32'd0, mstatus_o}, 64'h88);

        // Reset mid-operation drops the pending commit
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        rs1_addr = 5'd8;
        rs2_addr = 5'd5;
        issue(32'h8000_0600, 32'h0000_0413, 1, 5'd8, 0, 32'h88, 32'd0,
              4'b0001, 32'h0000_FFFF, 0, 0);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midrst_instret", instret, 64'd0);
        check("midrst_mstatus", {32'd0, mstatus_o}, 64'h1800);
        check("midrst_x8", {32'd0, rs1_data}, 64'd0);
        check("midrst_x5_cleared", {32'd0, rs2_data}, 64'd0);
        check("midrst_halt", {63'd0, halt}, 64'd0);
        check("midrst_ready", {63'd0, ready_last}, 64'd1);
        check("midrst_commit_valid", {63'd0, commit_valid}, 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
